// File: rtl/stepper_pkg.sv
// Shared types, phase table and phase-advance helper for the stepper sequencer.
package stepper_pkg;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    localparam logic [3:0] COAST = 4'b0000;

    // Even indices are the full-step patterns; odd indices are the half-step in-betweens.
    localparam logic [3:0] PHASE_LUT [0:7] = '{
        4'b1001, 4'b0001, 4'b0101, 4'b0100,
        4'b0110, 4'b0010, 4'b1010, 4'b1000
    };

    typedef struct packed {
        logic [2:0]        idx;
        logic signed [2:0] delta;
    } step_t;

    // Full-step from an odd index moves by one so the rotor snaps back onto a full-step pattern.
    function automatic step_t next_idx(input logic [2:0] idx, input logic dir, input logic half);
        logic [2:0] inc;
        step_t      r;
        inc = (half || idx[0]) ? 3'd1 : 3'd2;
        if (dir) begin
            r.idx   = idx + inc;
            r.delta = signed'(inc);
        end else begin
            r.idx   = idx - inc;
            r.delta = -signed'(inc);
        end
        return r;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Step-period down-counter: ticks while the count is zero, reloads on load.
module step_prescaler #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] value,
    output logic             tick
);

    logic [DIV_W-1:0] count;

    // Load has priority; otherwise count down and park at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - DIV_W'(1);
        end
    end

    assign tick = (count == '0);

endmodule

// File: rtl/stepper_sequencer.sv
// Stepper H-bridge sequencer: command handshake, step-rate control, abort and position tracking.
module stepper_sequencer
    import stepper_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned DIV_W = 16,
    parameter int unsigned POS_W = 32
) (
    input  logic                    clk,
    input  logic                    PRESET,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [CNT_W-1:0]        cmd_count,
    input  logic                    cmd_dir,
    input  logic                    cmd_half,
    input  logic [DIV_W-1:0]        cmd_div,
    input  logic                    abort,
    input  logic                    hold_en,
    output logic [3:0]              hb_state,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted,
    output logic [CNT_W-1:0]        steps_left,
    output logic signed [POS_W-1:0] position,
    output logic [2:0]              phase_idx
);

    state_t           state, state_nxt;
    logic             dir_q, half_q;
    logic [DIV_W-1:0] div_q;
    logic             tick;
    logic             accept, advance, finish, abort_end;
    logic             step_dir, step_half;
    logic [DIV_W-1:0] presc_val;
    step_t            step;

    // The first advance happens on the accept edge, so it must use the live command fields.
    assign step_dir  = accept ? cmd_dir  : dir_q;
    assign step_half = accept ? cmd_half : half_q;
    assign presc_val = accept ? cmd_div  : div_q;
    assign step      = next_idx(phase_idx, step_dir, step_half);

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state == S_RUN);

    step_prescaler #(.DIV_W(DIV_W)) u_presc (
        .clk   (clk),
        .rst   (PRESET),
        .load  (advance),
        .value (presc_val),
        .tick  (tick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (PRESET) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state and datapath controls; abort wins over a same-cycle prescaler expiry.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        advance   = 1'b0;
        finish    = 1'b0;
        abort_end = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    accept = 1'b1;
                    if (cmd_count != '0) begin
                        state_nxt = S_RUN;
                        advance   = 1'b1;
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                    abort_end = 1'b1;
                end else if (tick) begin
                    if (steps_left != '0) begin
                        advance = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        finish    = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Command latch, phase index, position, remaining count and completion flags.
    always_ff @(posedge clk) begin
        if (PRESET) begin
            dir_q      <= 1'b0;
            half_q     <= 1'b0;
            div_q      <= '0;
            phase_idx  <= '0;
            position   <= '0;
            steps_left <= '0;
            done       <= 1'b0;
            aborted    <= 1'b0;
        end else begin
            done <= finish | abort_end;
            if (accept) begin
                dir_q      <= cmd_dir;
                half_q     <= cmd_half;
                div_q      <= cmd_div;
                aborted    <= 1'b0;
                steps_left <= (cmd_count != '0) ? cmd_count - CNT_W'(1) : '0;
            end else if (advance) begin
                steps_left <= steps_left - CNT_W'(1);
            end
            if (abort_end) aborted <= 1'b1;
            if (advance) begin
                phase_idx <= step.idx;
                position  <= position + {{(POS_W-3){step.delta[2]}}, step.delta};
            end
        end
    end

    // Drive pattern: always energised while running, hold or coast when idle.
    always_comb begin
        hb_state = COAST;
        if (state == S_RUN || hold_en) hb_state = PHASE_LUT[phase_idx];
    end

endmodule
